load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store sequencer sitting directly upstream of the word-wide DataMemory.
//  Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
//  Sub-word stores are done as read-modify-write; load data is extracted and sign/zero-extended.
//  Stalls the pipeline while a multi-cycle access is in flight.
// PARAMETERS
//  DM_WORDS   32   number of 32-bit words in DataMemory; word index = req_addr[31:2]
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous reset, active-high
//  req_valid    in   1   pipeline presents a memory op; held stable while stall=1
//  req_we       in   1   1=store, 0=load
//  req_size     in   2   00=byte, 01=half, 10=word, 11=illegal (treated as fault)
//  req_unsigned in   1   loads only: 1=zero-extend, 0=sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data; the low byte/half is used for SB/SH
//  stall        out  1   freeze upstream stages
//  rdata_valid  out  1   one-cycle pulse; rdata holds the extended load result
//  rdata        out  32  registered load result, held until the next load completes
//  fault        out  1   one-cycle pulse: misaligned, out-of-range or illegal size; no memory access
//  dm_addr      out  32  to DataMemory DMaddr: zero-extended word index
//  dm_in        out  32  to DataMemory DMin
//  dm_wr        out  1   to DataMemory DMwr
//  dm_out       in   32  from DataMemory DMout; valid the cycle after a read is issued (dm_wr=0)
// BEHAVIOUR
//  Reset (sync): state<=IDLE; rdata<=0; rdata_valid<=0; fault<=0; latched request regs <=0.
//   dm_wr is forced to 0 combinationally while rst=1.
//  Little-endian lanes: byte k = bits[8k+7:8k], k = addr[1:0]; half = addr[1] ? [31:16] : [15:0].
//  Fault check in IDLE (combinational, on req_valid):
//   - half with addr[0]=1, or word with addr[1:0]!=0 -> misaligned
//   - addr[31:2] >= DM_WORDS -> out of range
//   - size=11 -> illegal
//   Any of these: fault pulses the next cycle, dm_wr=0, stall=0, state stays IDLE.
//  FSM states: IDLE, LD_WAIT, LD_DONE, RMW_MERGE, RMW_WRITE.
//  IDLE, accepted request (fields latched into addr_q/size_q/uns_q/wdata_q):
//   - SW: dm_wr=1, dm_in=req_wdata, stall=0; single cycle; stay IDLE.
//   - Load: dm_wr=0, dm_addr=word idx, stall=1 -> LD_WAIT.
//   - SB/SH: dm_wr=0 (read), stall=1 -> RMW_MERGE.
//  LD_WAIT: dm_out is valid; register rdata<=extend(lane(dm_out)), rdata_valid<=1; stall=1 -> LD_DONE.
//  LD_DONE: rdata_valid=1, stall=0; the pipeline advances this edge -> IDLE.
//   A new request is not accepted in LD_DONE.
//   Load occupancy: 3 cycles; rdata_valid asserts 2 cycles after acceptance.
//  RMW_MERGE: merged_q <= dm_out with the target lane(s) replaced by wdata_q; stall=1 -> RMW_WRITE.
//  RMW_WRITE: dm_wr=1, dm_in=merged_q, dm_addr=addr_q word; stall=0 -> IDLE.
//   Sub-word store occupancy: 3 cycles, exactly one write.
//  Outside the cycles above: dm_wr=0; dm_addr=current/latched word index; dm_in=0.
//  In non-IDLE states, addr/size/data come only from the latched regs; req_* is ignored until IDLE.
//  Extension: LB/LH replicate bit 7/15 into upper bits; LBU/LHU zero-fill; LW passes through unchanged.
//  Reset mid-operation: abort the access; no write is issued in the reset cycle or after;
//   stall=0 and rdata_valid=0 the next cycle.
//  rdata_valid and fault are never high in the same cycle.
// TESTING
//  1 SW 0xDEADBEEF @0x10, then LW @0x10 -> dm_wr=1 one cycle with dm_addr=4; rdata=0xDEADBEEF, rdata_valid 2 cycles after accept.
//  2 Word 4=0x11223344; SB 0xAA @0x12 -> single write of 0x11AA3344; stall high exactly 2 cycles.
//  3 Word 4=0x80FF7F01: LB @0x12 -> 0xFFFFFFFF; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80FF; LHU @0x10 -> 0x00007F01.
//  4 LH @0x11, SW @0x12, LW @0x80 (DM_WORDS=32) -> fault pulse each; dm_wr never 1; stall 0; memory unchanged.
//  5 SH 0xBEEF @0x16 with rst raised in RMW_MERGE -> no write issued; word 5 unchanged; all outputs at reset values the next cycle.
//  6 Back-to-back SW, SB, LW with req held while stall=1 -> each op executes exactly once, in order; LW returns the SB-merged word.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// MEM-stage sequencer in front of a word-wide, synchronous-read DataMemory.
// Converts RISC-V byte/half/word loads and stores into whole-word accesses:
//   - SW is a single-cycle write issued straight from the request.
//   - Loads read the word, then extract the lane and sign/zero-extend it.
//   - SB/SH read the word, merge the new lane(s), then write the word back.
// Upstream stages are frozen with stall while a multi-cycle access runs.
//
// State table
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | accept a request, run fault check, issue SW or the read
//   LD_WAIT     | read data on dm_out, register extended load result
//   LD_DONE     | rdata_valid high, stall released, pipeline advances
//   RMW_MERGE   | read data on dm_out, register merged word
//   RMW_WRITE   | write merged word back, stall released
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   req_valid     memory op presented (held stable while stall=1)
//   req_we        1=store, 0=load
//   req_size      00=byte, 01=half, 10=word, 11=illegal
//   req_unsigned  loads: 1=zero-extend, 0=sign-extend
//   req_addr      byte address
//   req_wdata     store data (low byte/half used for SB/SH)
//   stall         freeze upstream stages
//   rdata_valid   one-cycle pulse, rdata holds the load result
//   rdata         registered load result, held until the next load completes
//   fault         one-cycle pulse for misaligned/out-of-range/illegal size
//   dm_addr       DataMemory word index (zero-extended)
//   dm_in         DataMemory write data
//   dm_wr         DataMemory write enable
//   dm_out        DataMemory read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int DM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_in,
    output logic        dm_wr,
    input  logic [31:0] dm_out
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LD_WAIT   = 3'd1;
    localparam logic [2:0] S_LD_DONE   = 3'd2;
    localparam logic [2:0] S_RMW_MERGE = 3'd3;
    localparam logic [2:0] S_RMW_WRITE = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [29:0] DM_WORDS_W = 30'(DM_WORDS);

    logic [2:0]  state;
    logic [2:0]  state_nx;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [15:0] wdata_q;   // only the low half is ever needed after acceptance
    logic [31:0] merged_q;

    logic        req_misalign;
    logic        req_range;
    logic        req_illegal;
    logic        req_fault;
    logic        accept;

    logic        stall_c;
    logic        wr_c;
    logic [31:0] dm_addr_c;
    logic [31:0] dm_in_c;

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] ld_ext;
    logic [31:0] merge_c;

    // ---------------------------------------------------------------------
    // Request screening (IDLE only)
    // ---------------------------------------------------------------------
    always_comb begin
        req_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        req_range    = (req_addr[31:2] >= DM_WORDS_W);
        req_illegal  = (req_size == SZ_ILL);
        req_fault    = req_misalign | req_range | req_illegal;
        accept       = (state == S_IDLE) && req_valid && !req_fault;
    end

    // ---------------------------------------------------------------------
    // Next state and memory-side drive
    // ---------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        stall_c   = 1'b0;
        wr_c      = 1'b0;
        dm_addr_c = {2'b00, addr_q[31:2]};
        dm_in_c   = 32'h0;

        case (state)
            S_IDLE: begin
                dm_addr_c = {2'b00, req_addr[31:2]};
                if (accept) begin
                    if (req_we && (req_size == SZ_WORD)) begin
                        wr_c    = 1'b1;
                        dm_in_c = req_wdata;
                    end else if (req_we) begin
                        stall_c  = 1'b1;
                        state_nx = S_RMW_MERGE;
                    end else begin
                        stall_c  = 1'b1;
                        state_nx = S_LD_WAIT;
                    end
                end
            end
            S_LD_WAIT: begin
                stall_c  = 1'b1;
                state_nx = S_LD_DONE;
            end
            S_LD_DONE: begin
                // Pipeline advances on this edge; the held request is the
                // load that just finished, so nothing is accepted here.
                state_nx = S_IDLE;
            end
            S_RMW_MERGE: begin
                stall_c  = 1'b1;
                state_nx = S_RMW_WRITE;
            end
            S_RMW_WRITE: begin
                wr_c     = 1'b1;
                dm_in_c  = merged_q;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // A reset cycle must never write memory, whatever state we are in.
    assign dm_wr   = wr_c & ~rst;
    assign stall   = stall_c & ~rst;
    assign dm_addr = dm_addr_c;
    assign dm_in   = dm_in_c;

    // ---------------------------------------------------------------------
    // Load lane extraction and extension
    // ---------------------------------------------------------------------
    always_comb begin
        lane_byte = 8'h0;
        case (addr_q[1:0])
            2'd0:    lane_byte = dm_out[7:0];
            2'd1:    lane_byte = dm_out[15:8];
            2'd2:    lane_byte = dm_out[23:16];
            default: lane_byte = dm_out[31:24];
        endcase

        lane_half = addr_q[1] ? dm_out[31:16] : dm_out[15:0];

        case (size_q)
            SZ_BYTE: ld_ext = uns_q ? {24'h0, lane_byte}
                                    : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: ld_ext = uns_q ? {16'h0, lane_half}
                                    : {{16{lane_half[15]}}, lane_half};
            default: ld_ext = dm_out;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sub-word store merge
    // ---------------------------------------------------------------------
    always_comb begin
        merge_c = dm_out;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merge_c[7:0]   = wdata_q[7:0];
                2'd1:    merge_c[15:8]  = wdata_q[7:0];
                2'd2:    merge_c[23:16] = wdata_q[7:0];
                default: merge_c[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_c[31:16] = wdata_q;
        end else begin
            merge_c[15:0] = wdata_q;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_q      <= 32'h0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 16'h0;
            merged_q    <= 32'h0;
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nx;
            rdata_valid <= (state == S_LD_WAIT);
            fault       <= (state == S_IDLE) && req_valid && req_fault;

            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata[15:0];
            end

            if (state == S_LD_WAIT) begin
                rdata <= ld_ext;
            end

            if (state == S_RMW_MERGE) begin
                merged_q <= merge_c;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] dm_addr;
    logic [31:0] dm_in;
    logic        dm_wr;
    logic [31:0] dm_out;

    always #5 clk = ~clk;

    load_store_unit #(.DM_WORDS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rdata_valid  (rdata_valid),
        .rdata        (rdata),
        .fault        (fault),
        .dm_addr      (dm_addr),
        .dm_in        (dm_in),
        .dm_wr        (dm_wr),
        .dm_out       (dm_out)
    );

    // Synchronous-read DataMemory model
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (dm_wr) mem[dm_addr[4:0]] <= dm_in;
        dm_out <= mem[dm_addr[4:0]];
    end

    // exp: word written for stores, extended result for loads
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        flt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        is_fault;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];
    ev_t  ev_q[$];
    wr_t  wr_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Per-cycle scoreboard check, called at the negedge
    task automatic mon();
        ev_t e;
        wr_t w;
        chk("valid_fault_excl", {31'b0, rdata_valid & fault}, 32'd0);
        if (dm_wr) begin
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write actual addr=%h data=%h required none", dm_addr, dm_in);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", dm_addr, w.addr);
                chk("wr_data", dm_in, w.data);
            end
        end
        if (rdata_valid) begin
            if (ev_q.size() == 0 || ev_q[0].is_fault) begin
                total++; bad++;
                $display("FAIL unexpected_rdata actual=%h required no load result", rdata);
            end else begin
                e = ev_q.pop_front();
                chk("rdata", rdata, e.data);
            end
        end
        if (fault) begin
            if (ev_q.size() == 0 || !ev_q[0].is_fault) begin
                total++; bad++;
                $display("FAIL unexpected_fault actual=1 required=0");
            end else begin
                e = ev_q.pop_front();
                chk("fault", {31'b0, fault}, {31'b0, e.is_fault});
            end
        end
    endtask

    task automatic cyc(output logic st, output logic rv);
        @(negedge clk);
        mon();
        st = stall;
        rv = rdata_valid;
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until stall drops
    task automatic do_op(input vec_t v);
        int   stalls = 0;
        int   exp_st;
        logic st;
        logic rv = 1'b0;
        bit   done = 0;
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        if (v.flt)      ev_q.push_back('{1'b1, 32'h0});
        else if (v.we)  wr_q.push_back('{{2'b00, v.addr[31:2]}, v.exp});
        else            ev_q.push_back('{1'b0, v.exp});
        exp_st = (v.flt || (v.we && v.size == 2'b10)) ? 0 : 2;
        for (int n = 0; n < 10; n++) begin
            cyc(st, rv);
            if (!st) begin
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL stall_timeout addr=%h actual stall stuck required release", v.addr);
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_st));
        if (!v.we && !v.flt) chk("rv_at_release", {31'b0, rv}, 32'd1);
    endtask

    initial begin
        logic st, rv;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        //             we    size   uns   addr      wdata          flt   exp
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h11223344});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h12, 32'h555555AA, 1'b0, 32'h11AA3344});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h11AA3344});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 1'b0, 32'h80FF7F01});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        1'b0, 32'hFFFFFFFF});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        1'b0, 32'h00000080});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        1'b0, 32'hFFFF80FF});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        1'b0, 32'h00007F01});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        1'b0, 32'h00000001});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h80FF7F01});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        1'b0, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0C, 32'h00000000, 1'b0, 32'h00000000});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFFBEEF, 1'b0, 32'hBEEF0000});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0E, 32'h0,        1'b0, 32'hFFFFBEEF});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0E, 32'h0,        1'b0, 32'h0000BEEF});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0C, 32'h12345677, 1'b0, 32'hBEEF0077});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0F, 32'h000000C3, 1'b0, 32'hC3EF0077});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        1'b0, 32'hC3EF0077});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h14, 32'h01234567, 1'b0, 32'h01234567});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        1'b0, 32'h01234567});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall",  {31'b0, stall},       32'd0);
        chk("rst_rvalid", {31'b0, rdata_valid}, 32'd0);
        chk("rst_fault",  {31'b0, fault},       32'd0);
        chk("rst_rdata",  rdata,                32'd0);
        chk("rst_dm_wr",  {31'b0, dm_wr},       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Requests are applied back to back: each new op is presented on
        // the cycle after the previous one released stall.
        foreach (vecs[i]) do_op(vecs[i]);
        req_valid = 1'b0;
        cyc(st, rv);

        // Reset during RMW_MERGE of an SH to word 5
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h16; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
        cyc(st, rv);
        chk("rmw_accept_stall", {31'b0, st}, 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        cyc(st, rv);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall",  {31'b0, stall},       32'd0);
        chk("post_rst_rvalid", {31'b0, rdata_valid}, 32'd0);
        chk("post_rst_fault",  {31'b0, fault},       32'd0);
        chk("post_rst_rdata",  rdata,                32'd0);
        chk("post_rst_dm_wr",  {31'b0, dm_wr},       32'd0);
        mon();
        @(posedge clk);
        #1;
        do_op('{1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'h01234567});
        req_valid = 1'b0;

        repeat (3) cyc(st, rv);
        chk("events_drained", 32'(ev_q.size()), 32'd0);
        chk("writes_drained", 32'(wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
